// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the cache/memory arbiter: FSM states, grant codes and memory direction.
// Optional feature macro used by this slice: ARB_ROUND_ROBIN_EN.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_BUSY = 2'd1,
      ARB_RESP = 2'd2
   } arb_state_e;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_IC   = 2'd1,
      GNT_DCR  = 2'd2,
      GNT_DCW  = 2'd3
   } gnt_e;

   localparam logic MEM_RD = 1'b0;
   localparam logic MEM_WR = 1'b1;

endpackage

// File: rtl/mem_arbiter_arb_grant.sv
// Combinational grant selection between Icache read, Dcache read and Dcache write-back.
// ARB_ROUND_ROBIN_EN selects Icache vs Dcache-group round robin; otherwise fixed priority.
module arb_grant
   import mem_arbiter_pkg::*;
(
   input  logic ic_req,
   input  logic dcr_req,
   input  logic dcw_req,
   input  logic last_dc,
   output gnt_e gnt
);

   gnt_e dc_gnt;

   // Write-back always beats the fill inside the Dcache group.
   always_comb begin
      dc_gnt = GNT_NONE;
      if (dcw_req) begin
         dc_gnt = GNT_DCW;
      end else if (dcr_req) begin
         dc_gnt = GNT_DCR;
      end
   end

`ifdef ARB_ROUND_ROBIN_EN
   always_comb begin
      gnt = dc_gnt;
      if (ic_req && ((dc_gnt == GNT_NONE) || last_dc)) begin
         gnt = GNT_IC;
      end
   end
`else
   logic unused_last_dc;
   assign unused_last_dc = last_dc;

   always_comb begin
      gnt = dc_gnt;
      if ((dc_gnt == GNT_NONE) && ic_req) begin
         gnt = GNT_IC;
      end
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Serialises Icache fills, Dcache fills and Dcache write-backs onto one memory port.
// Grant policy follows ARB_ROUND_ROBIN_EN (see arb_grant); default is fixed priority.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int WIDTH = 128,
   parameter int ASIZE = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ic_read_req,
   input  logic [ASIZE-1:0] ic_read_addr,
   output logic             ic_read_ack,
   output logic [WIDTH-1:0] ic_read_data,
   input  logic             dc_read_req,
   input  logic [ASIZE-1:0] dc_read_addr,
   output logic             dc_read_ack,
   output logic [WIDTH-1:0] dc_read_data,
   input  logic             dc_write_req,
   input  logic [ASIZE-1:0] dc_write_addr,
   input  logic [WIDTH-1:0] dc_write_data,
   output logic             dc_write_ack,
   output logic             mem_enable,
   output logic             mem_rw,
   input  logic             mem_ack,
   output logic [ASIZE-1:0] mem_addr,
   input  logic [WIDTH-1:0] mem_data_in,
   output logic [WIDTH-1:0] mem_data_out,
   output logic [1:0]       dbg_state
);

   arb_state_e state, state_nxt;
   gnt_e       gnt, gnt_q;
   logic       last_dc;
   logic       take_grant;
   logic       mem_done;

   arb_grant u_grant (
      .ic_req  (ic_read_req),
      .dcr_req (dc_read_req),
      .dcw_req (dc_write_req),
      .last_dc (last_dc),
      .gnt     (gnt)
   );

   assign take_grant = (state == ARB_IDLE) && (gnt != GNT_NONE);
   assign mem_done   = (state == ARB_BUSY) && mem_ack;
   assign mem_enable = (state == ARB_BUSY);
   assign dbg_state  = state;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ARB_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ARB_IDLE: if (gnt != GNT_NONE) state_nxt = ARB_BUSY;
         ARB_BUSY: if (mem_ack) state_nxt = ARB_RESP;
         ARB_RESP: state_nxt = ARB_IDLE;
         default:  state_nxt = ARB_IDLE;
      endcase
   end

   // Request latch. A write-back does not use up the Dcache turn, so its
   // follow-on fill still goes ahead of a waiting Icache request.
   always_ff @(posedge clk) begin
      if (reset) begin
         gnt_q        <= GNT_NONE;
         last_dc      <= 1'b0;
         mem_addr     <= '0;
         mem_rw       <= MEM_RD;
         mem_data_out <= '0;
      end else if (take_grant) begin
         gnt_q <= gnt;
         case (gnt)
            GNT_DCW: begin
               mem_addr     <= dc_write_addr;
               mem_rw       <= MEM_WR;
               mem_data_out <= dc_write_data;
            end
            GNT_DCR: begin
               mem_addr <= dc_read_addr;
               mem_rw   <= MEM_RD;
               last_dc  <= 1'b1;
            end
            default: begin
               mem_addr <= ic_read_addr;
               mem_rw   <= MEM_RD;
               last_dc  <= 1'b0;
            end
         endcase
      end
   end

   // Response registers: only the winner's ack and data move.
   always_ff @(posedge clk) begin
      if (reset) begin
         ic_read_ack  <= 1'b0;
         dc_read_ack  <= 1'b0;
         dc_write_ack <= 1'b0;
         ic_read_data <= '0;
         dc_read_data <= '0;
      end else begin
         ic_read_ack  <= 1'b0;
         dc_read_ack  <= 1'b0;
         dc_write_ack <= 1'b0;
         if (mem_done) begin
            case (gnt_q)
               GNT_IC: begin
                  ic_read_ack  <= 1'b1;
                  ic_read_data <= mem_data_in;
               end
               GNT_DCR: begin
                  dc_read_ack  <= 1'b1;
                  dc_read_data <= mem_data_in;
               end
               GNT_DCW: dc_write_ack <= 1'b1;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed checks of mem_arbiter against a transaction-level reference model.
// Honours ARB_ROUND_ROBIN_EN in its arbitration model.
module tb_mem_arbiter;

   localparam int WIDTH = 128;
   localparam int ASIZE = 32;

   // clock / reset
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic             ic_read_req, dc_read_req, dc_write_req;
   logic [ASIZE-1:0] ic_read_addr, dc_read_addr, dc_write_addr;
   logic [WIDTH-1:0] dc_write_data;
   logic             ic_read_ack, dc_read_ack, dc_write_ack;
   logic [WIDTH-1:0] ic_read_data, dc_read_data;
   logic             mem_enable, mem_rw, mem_ack;
   logic [ASIZE-1:0] mem_addr;
   logic [WIDTH-1:0] mem_data_in, mem_data_out;
   logic [1:0]       dbg_state;

   mem_arbiter #(.WIDTH(WIDTH), .ASIZE(ASIZE)) dut (
      .clk           (clk),
      .reset         (reset),
      .ic_read_req   (ic_read_req),
      .ic_read_addr  (ic_read_addr),
      .ic_read_ack   (ic_read_ack),
      .ic_read_data  (ic_read_data),
      .dc_read_req   (dc_read_req),
      .dc_read_addr  (dc_read_addr),
      .dc_read_ack   (dc_read_ack),
      .dc_read_data  (dc_read_data),
      .dc_write_req  (dc_write_req),
      .dc_write_addr (dc_write_addr),
      .dc_write_data (dc_write_data),
      .dc_write_ack  (dc_write_ack),
      .mem_enable    (mem_enable),
      .mem_rw        (mem_rw),
      .mem_ack       (mem_ack),
      .mem_addr      (mem_addr),
      .mem_data_in   (mem_data_in),
      .mem_data_out  (mem_data_out),
      .dbg_state     (dbg_state)
   );

   int total = 0;
   int bad   = 0;

   task automatic check_eq(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // requester stimulus: index 0 = Icache read, 1 = Dcache read, 2 = Dcache write-back
   bit               rq[3];
   logic [ASIZE-1:0] ad[3];
   logic [WIDTH-1:0] wd;
   bit               mem_auto, stray_en;

   // reference model: one open transaction at most; listens again one cycle after its ack
   bit               own_v, cool, last_dc;
   int               own;
   logic [WIDTH-1:0] exp_data[2];
   logic [ASIZE-1:0] exp_addr;
   logic             exp_rw;
   logic [WIDTH-1:0] exp_wdata;
   logic [ASIZE-1:0] exp_q[$];   // observed grant addresses, in order
   bit               prev_en;
   int               n_dcr_ack;

   function automatic logic [WIDTH-1:0] rnd_line();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic int pick();
`ifdef ARB_ROUND_ROBIN_EN
      if (rq[0] && (!(rq[1] || rq[2]) || last_dc)) return 0;
`endif
      if (rq[2]) return 2;
      if (rq[1]) return 1;
      return 0;
   endfunction

   // driver + model + checker for one clock
   task automatic step();
      int who;
      bit hit_reset;
      if (mem_auto) begin
         mem_ack     = mem_enable ? ($urandom_range(0, 2) == 0) : (stray_en && $urandom_range(0, 5) == 0);
         mem_data_in = rnd_line();
      end
      ic_read_req   = rq[0];  ic_read_addr  = ad[0];
      dc_read_req   = rq[1];  dc_read_addr  = ad[1];
      dc_write_req  = rq[2];  dc_write_addr = ad[2];
      dc_write_data = wd;

      who = -1;
      hit_reset = reset;
      if (reset) begin
         own_v = 0; cool = 0; last_dc = 0;
         exp_data[0] = '0; exp_data[1] = '0;
         exp_addr = '0; exp_rw = 1'b0; exp_wdata = '0;
      end else if (cool) begin
         cool = 0;
      end else if (own_v) begin
         if (mem_ack) begin
            who = own; own_v = 0; cool = 1;
            if (own != 2) exp_data[own] = mem_data_in;
         end
      end else if (rq[0] || rq[1] || rq[2]) begin
         own = pick(); own_v = 1;
         exp_addr = ad[own];
         exp_rw = (own == 2);
         if (own == 2) exp_wdata = wd;
         if (own == 1) last_dc = 1;
         if (own == 0) last_dc = 0;
      end

      @(posedge clk);
      #1;
      check_eq("mem_enable", mem_enable, own_v);
      check_eq("ic_read_ack", ic_read_ack, who == 0);
      check_eq("dc_read_ack", dc_read_ack, who == 1);
      check_eq("dc_write_ack", dc_write_ack, who == 2);
      check_eq("ic_read_data", ic_read_data, exp_data[0]);
      check_eq("dc_read_data", dc_read_data, exp_data[1]);
      if (own_v || hit_reset) begin
         check_eq("mem_addr", mem_addr, exp_addr);
         check_eq("mem_rw", mem_rw, exp_rw);
      end
      if ((own_v && exp_rw) || hit_reset) check_eq("mem_data_out", mem_data_out, exp_wdata);
      if (hit_reset) check_eq("reset_state", dbg_state, 2'd0);

      if (who >= 0) rq[who] = 0;
      if (mem_enable && !prev_en) exp_q.push_back(mem_addr);
      prev_en = mem_enable;
      if (dc_read_ack) n_dcr_ack++;
   endtask

   task automatic drain(input int budget, input string tag);
      int k;
      for (k = 0; k < budget && (rq[0] || rq[1] || rq[2] || own_v || cool); k++) step();
      check_eq(tag, k < budget, 1'b1);
   endtask

   int who_seq[$];

   initial begin
      mem_auto = 0; stray_en = 0; prev_en = 0; n_dcr_ack = 0;
      own_v = 0; cool = 0; last_dc = 0; own = 0;
      wd = '0;
      for (int i = 0; i < 3; i++) ad[i] = '0;

      // 1. reset with garbage on every input
      reset = 1;
      for (int i = 0; i < 3; i++) begin rq[i] = 1; ad[i] = $urandom; end
      wd = rnd_line(); mem_ack = 1; mem_data_in = rnd_line();
      step(); step();
      reset = 0;
      for (int i = 0; i < 3; i++) rq[i] = 0;

      // 6. stray mem_ack while idle
      mem_ack = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq("stray_idle_state", dbg_state, 2'd0);
      end
      mem_ack = 0;

      // 2. single Icache fill
      rq[0] = 1; ad[0] = 32'h0000_1000;
      step();
      check_eq("t2_enable", mem_enable, 1'b1);
      check_eq("t2_addr", mem_addr, 32'h0000_1000);
      step(); step();
      mem_ack = 1; mem_data_in = 128'hDEADBEEF_0123_4567_89AB_CDEF_0011_2233;
      step();
      check_eq("t2_ack", ic_read_ack, 1'b1);
      check_eq("t2_data", ic_read_data, 128'hDEADBEEF_0123_4567_89AB_CDEF_0011_2233);
      mem_ack = 0; mem_data_in = rnd_line();
      step();
      check_eq("t2_ack_pulse", ic_read_ack, 1'b0);
      step();

      // 3. all three at once
      exp_q.delete();
      mem_auto = 1; stray_en = 1;
      rq[2] = 1; ad[2] = 32'h2000; wd = rnd_line();
      rq[1] = 1; ad[1] = 32'h3000;
      rq[0] = 1; ad[0] = 32'h4000;
      drain(200, "t3_timeout");
      check_eq("t3_count", exp_q.size(), 3);
      if (exp_q.size() == 3) begin
         check_eq("t3_first", exp_q[0], 32'h2000);
         check_eq("t3_second", exp_q[1], 32'h3000);
         check_eq("t3_third", exp_q[2], 32'h4000);
      end

      // 4. continuous Dcache fills with a waiting Icache fill
      exp_q.delete();
      rq[0] = 1; ad[0] = 32'h4000;
      rq[1] = 1; ad[1] = 32'h3000;
      for (int k = 0; k < 400 && exp_q.size() < 4; k++) begin
         step();
         if (!rq[0]) begin rq[0] = 1; ad[0] = 32'h4000 + 32'(k); end
         if (!rq[1]) begin rq[1] = 1; ad[1] = 32'h3000 + 32'(k); end
      end
      check_eq("t4_count", exp_q.size(), 4);
      foreach (exp_q[i]) who_seq.push_back(exp_q[i][15:12] == 4'h4 ? 0 : 1);
      for (int i = 0; i < who_seq.size() && i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
         check_eq("t4_alternate", who_seq[i], (i % 2 == 0) ? 1 : 0);
`else
         check_eq("t4_fixed", who_seq[i], 1);
`endif
      end

      // 5. reset while a read is in BUSY, with a simultaneous mem_ack
      mem_auto = 0; mem_ack = 0;
      for (int k = 0; k < 20 && !mem_enable; k++) step();
      check_eq("t5_busy", mem_enable, 1'b1);
      reset = 1; mem_ack = 1;
      for (int i = 0; i < 3; i++) rq[i] = 0;
      step();
      reset = 0; mem_ack = 0;
      n_dcr_ack = 0;
      for (int i = 0; i < 4; i++) step();
      check_eq("t5_no_ack", n_dcr_ack + int'(ic_read_ack), 0);
      mem_auto = 1;
      rq[1] = 1; ad[1] = 32'h5000;
      drain(200, "t5_timeout");
      check_eq("t5_reserve", n_dcr_ack, 1);

      // random traffic with dropped requests, address churn and stray acks
      for (int k = 0; k < 1500; k++) begin
         for (int i = 0; i < 3; i++) begin
            if (!rq[i] && $urandom_range(0, 3) == 0) begin
               rq[i] = 1; ad[i] = $urandom;
               if (i == 2) wd = rnd_line();
            end else if (rq[i] && $urandom_range(0, 40) == 0) begin
               rq[i] = 0;
            end else if (rq[i] && $urandom_range(0, 15) == 0) begin
               ad[i] = $urandom;
               if (i == 2) wd = rnd_line();
            end
         end
         step();
      end
      for (int i = 0; i < 3; i++) rq[i] = 0;
      drain(200, "final_drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
